thermo_ctrl: RTL and testbench

- Sequential, parametrised successor to the combinational thermostat comparator.
- Adds:
  - registered heater and cooler outputs;
  - hysteresis with a programmable deadband;
  - operating modes (off, heat-only, cool-only, auto);
  - a minimum on-time and a mandatory lockout between actuator changes, to protect the compressor and heater.
- Sits between the temperature-sensor sampling logic and the actuator drivers.

---
 rtl/thermo_pkg.sv | 27 ++
 rtl/thermo_hold_timer.sv | 26 ++
 rtl/thermo_ctrl.sv | 112 +++++++++++
 tb/tb_thermo_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// rtl/thermo_pkg.sv - shared state/mode encodings and width helper for the thermostat controller
package thermo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    HEAT    = 2'b01,
    COOL    = 2'b10,
    LOCKOUT = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_HEAT = 2'b01,
    MODE_COOL = 2'b10,
    MODE_AUTO = 2'b11
  } mode_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/thermo_hold_timer.sv
// rtl/thermo_hold_timer.sv - load-then-saturating-decrement hold counter
module thermo_hold_timer #(
  parameter int CNT_W    = 5,
  parameter int MIN_HOLD = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(MIN_HOLD - 1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/thermo_ctrl.sv
// rtl/thermo_ctrl.sv - hysteresis thermostat FSM with modes, minimum on-time and lockout
module thermo_ctrl
  import thermo_pkg::*;
#(
  parameter int SIZE     = 8,
  parameter int BAND     = 4,
  parameter int MIN_HOLD = 16,
  parameter int CNT_W    = clog2(MIN_HOLD + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] Tset,
  input  logic [SIZE-1:0] Tact,
  input  logic            sample_valid,
  input  logic [1:0]      mode,
  output logic            Hon,
  output logic            Con,
  output logic [1:0]      state
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_HEAT = HEAT;
  localparam logic [1:0] S_COOL = COOL;
  localparam logic [1:0] S_LOCK = LOCKOUT;

  // One extra bit so that adding the deadband can never wrap.
  logic [SIZE:0] tset_x;
  logic [SIZE:0] tact_x;
  logic [SIZE:0] band_x;

  assign tset_x = {1'b0, Tset};
  assign tact_x = {1'b0, Tact};
  assign band_x = (SIZE + 1)'(BAND);

  logic heat_en;
  logic cool_en;
  logic heat_req;
  logic cool_req;
  logic heat_done;
  logic cool_done;

  assign heat_en   = (mode == MODE_HEAT) || (mode == MODE_AUTO);
  assign cool_en   = (mode == MODE_COOL) || (mode == MODE_AUTO);
  assign heat_req  = ((tact_x + band_x) < tset_x) && heat_en;
  assign cool_req  = (tact_x > (tset_x + band_x)) && cool_en;
  assign heat_done = (tact_x >= tset_x);
  assign cool_done = (tact_x <= tset_x);

  logic       expired;
  logic       load;
  logic [1:0] next_state;

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (sample_valid) begin
          if (heat_req) begin
            next_state = S_HEAT;
          end else if (cool_req) begin
            next_state = S_COOL;
          end
        end
      end
      S_HEAT: begin
        // Losing heat permission exits at once, ignoring the minimum on-time.
        if (!heat_en) begin
          next_state = S_LOCK;
        end else if (sample_valid && expired && heat_done) begin
          next_state = S_LOCK;
        end
      end
      S_COOL: begin
        if (!cool_en) begin
          next_state = S_LOCK;
        end else if (sample_valid && expired && cool_done) begin
          next_state = S_LOCK;
        end
      end
      default: begin
        if (expired) begin
          next_state = S_IDLE;
        end
      end
    endcase
  end

  assign load = (next_state != state) && (next_state != S_IDLE);

  thermo_hold_timer #(
    .CNT_W    (CNT_W),
    .MIN_HOLD (MIN_HOLD)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      Hon   <= 1'b0;
      Con   <= 1'b0;
    end else begin
      state <= next_state;
      Hon   <= (next_state == S_HEAT);
      Con   <= (next_state == S_COOL);
    end
  end

endmodule

// File: tb/tb_thermo_ctrl.sv
// tb/tb_thermo_ctrl.sv - directed and randomized checks of thermo_ctrl against a behavioural model
module tb_thermo_ctrl;

  localparam int SIZE     = 8;
  localparam int BAND     = 4;
  localparam int MIN_HOLD = 4;

  logic            clk;
  logic            rst_n;
  logic [SIZE-1:0] Tset;
  logic [SIZE-1:0] Tact;
  logic            sample_valid;
  logic [1:0]      mode;
  logic            Hon;
  logic            Con;
  logic [1:0]      state;

  int n_checks = 0;
  int n_pass   = 0;

  thermo_ctrl #(
    .SIZE     (SIZE),
    .BAND     (BAND),
    .MIN_HOLD (MIN_HOLD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Tset         (Tset),
    .Tact         (Tact),
    .sample_valid (sample_valid),
    .mode         (mode),
    .Hon          (Hon),
    .Con          (Con),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: state 0 idle, 1 heat, 2 cool, 3 lockout; m_held counts edges spent in the current state.
  int m_state = 0;
  int m_held  = 0;
  int m_next;
  bit m_hreq;
  bit m_creq;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_held  = 0;
    end else begin
      m_held = m_held + 1;
      m_hreq = (int'(Tact) + BAND < int'(Tset)) && (mode == 2'd1 || mode == 2'd3);
      m_creq = (int'(Tact) > int'(Tset) + BAND) && (mode == 2'd2 || mode == 2'd3);
      m_next = m_state;
      if (m_state == 0) begin
        if (sample_valid && m_hreq) m_next = 1;
        else if (sample_valid && m_creq) m_next = 2;
      end else if (m_state == 1) begin
        if (mode == 2'd0 || mode == 2'd2) m_next = 3;
        else if (sample_valid && m_held >= MIN_HOLD && Tact >= Tset) m_next = 3;
      end else if (m_state == 2) begin
        if (mode == 2'd0 || mode == 2'd1) m_next = 3;
        else if (sample_valid && m_held >= MIN_HOLD && Tact <= Tset) m_next = 3;
      end else begin
        if (m_held >= MIN_HOLD) m_next = 0;
      end
      if (m_next != m_state) m_held = 0;
      m_state = m_next;
    end
  end

  always @(negedge clk) begin
    check("model_state", int'(state), m_state);
    check("model_hon", int'(Hon), int'(m_state == 1));
    check("model_con", int'(Con), int'(m_state == 2));
    check("exclusive", int'(Hon && Con), 0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int tset, input int tact, input bit valid, input logic [1:0] md);
    Tset         = SIZE'(tset);
    Tact         = SIZE'(tact);
    sample_valid = valid;
    mode         = md;
  endtask

  task automatic expect_out(input string name, input int st, input int h, input int c);
    check({name, "_state"}, int'(state), st);
    check({name, "_hon"}, int'(Hon), h);
    check({name, "_con"}, int'(Con), c);
  endtask

  task automatic to_idle();
    drive(25, 25, 1'b0, 2'd0);
    repeat (6) tick();
    expect_out("to_idle", 0, 0, 0);
    mode = 2'd3;
  endtask

  int tset_r;
  int tact_r;

  initial begin
    rst_n = 1'b1;
    drive(25, 25, 1'b0, 2'd3);
    #1 rst_n = 1'b0;
    tick();
    tick();
    expect_out("reset", 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Heat cycle with hysteresis and lockout length
    drive(25, 20, 1'b1, 2'd3); tick(); expect_out("heat_enter", 1, 1, 0);
    drive(25, 24, 1'b1, 2'd3); tick(); expect_out("heat_band", 1, 1, 0);
    sample_valid = 1'b0; tick(); tick(); expect_out("heat_novalid", 1, 1, 0);
    drive(25, 25, 1'b1, 2'd3); tick(); expect_out("heat_done", 3, 0, 0);
    sample_valid = 1'b0;
    repeat (3) begin tick(); expect_out("lockout_hold", 3, 0, 0); end
    tick(); expect_out("lockout_end", 0, 0, 0);

    // Deadband boundaries
    drive(25, 21, 1'b1, 2'd3); tick(); expect_out("band_t21", 0, 0, 0);
    drive(25, 29, 1'b1, 2'd3); tick(); expect_out("band_t29", 0, 0, 0);
    drive(25, 30, 1'b1, 2'd3); tick(); expect_out("band_t30", 2, 0, 1);
    to_idle();
    drive(25, 20, 1'b1, 2'd3); tick(); expect_out("band_t20", 1, 1, 0);
    to_idle();

    // No wrap in the deadband arithmetic
    drive(254, 255, 1'b1, 2'd3); tick(); expect_out("ovf_cool", 0, 0, 0);
    drive(255, 250, 1'b1, 2'd3); tick(); expect_out("ovf_heat", 1, 1, 0);
    to_idle();
    drive(3, 0, 1'b1, 2'd3); tick(); expect_out("low_heat", 0, 0, 0);

    // Minimum hold
    drive(25, 20, 1'b1, 2'd3); tick(); expect_out("hold_enter", 1, 1, 0);
    drive(25, 26, 1'b1, 2'd3);
    repeat (3) begin tick(); expect_out("hold_keep", 1, 1, 0); end
    tick(); expect_out("hold_exit", 3, 0, 0);
    to_idle();

    // Mode override from HEAT without a valid sample
    drive(25, 20, 1'b1, 2'd3); tick(); expect_out("ovr_enter", 1, 1, 0);
    drive(25, 20, 1'b0, 2'd0); tick(); expect_out("ovr_exit", 3, 0, 0);
    to_idle();

    // No direct HEAT to COOL swap
    drive(25, 20, 1'b1, 2'd3); tick(); expect_out("swap_heat", 1, 1, 0);
    drive(25, 40, 1'b1, 2'd3);
    repeat (3) begin tick(); expect_out("swap_hold", 1, 1, 0); end
    tick(); expect_out("swap_lock", 3, 0, 0);
    repeat (3) begin tick(); expect_out("swap_lockhold", 3, 0, 0); end
    tick(); expect_out("swap_idle", 0, 0, 0);
    tick(); expect_out("swap_cool", 2, 0, 1);
    to_idle();

    // Heat-only mode never cools
    drive(25, 40, 1'b1, 2'd1);
    repeat (5) begin tick(); expect_out("heatonly", 0, 0, 0); end
    to_idle();

    // Asynchronous reset while cooling
    drive(25, 40, 1'b1, 2'd3); tick(); expect_out("rst_cool", 2, 0, 1);
    #1 rst_n = 1'b0;
    #1 expect_out("rst_async", 0, 0, 0);
    tick(); tick();
    expect_out("rst_held", 0, 0, 0);
    rst_n = 1'b1;
    tick(); expect_out("rst_release", 2, 0, 1);
    to_idle();

    // Randomized phase checked every cycle by the model
    tset_r = 25;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) tset_r = int'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) begin
        tact_r = ($urandom_range(0, 1) == 1) ? 255 : 0;
      end else begin
        tact_r = tset_r + int'($urandom_range(0, 20)) - 10;
      end
      if (tact_r < 0) tact_r = 0;
      if (tact_r > 255) tact_r = 255;
      Tset         = SIZE'(tset_r);
      Tact         = SIZE'(tact_r);
      sample_valid = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 999) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
